// File: rtl/dram_pkg.sv
// Shared types for the DRAM array controller: FSM state encoding and a state helper.
package dram_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, REFRESH} dram_state_e;

  function automatic logic accepts_req(input dram_state_e s);
    return s == IDLE;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-response delay line: RD_LAT-deep shift register of {valid, data[, par]} entries.
// Optional parity sideband is present when DRAM_PARITY_EN is defined.
module dram_rd_pipe
  import dram_pkg::*;
#(
  parameter int DATA_W = 72,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef DRAM_PARITY_EN
  input  logic              par_i,
  output logic              par_o,
`endif
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
`ifdef DRAM_PARITY_EN
    logic              par;
`endif
  } entry_t;

  entry_t pipe_q [RD_LAT];
  entry_t in_d;

  // Idle slots carry zero data so the output needs no extra gating.
  always_comb begin
    in_d       = '0;
    in_d.valid = valid_i;
    in_d.data  = valid_i ? data_i : '0;
`ifdef DRAM_PARITY_EN
    in_d.par   = valid_i & par_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= in_d;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_q[i].valid) empty_o = 1'b0;
    end
  end

  assign valid_o = pipe_q[RD_LAT-1].valid;
  assign data_o  = pipe_q[RD_LAT-1].data;
`ifdef DRAM_PARITY_EN
  assign par_o   = pipe_q[RD_LAT-1].par;
`endif

endmodule

// File: rtl/dram_array_ctrl.sv
// Parametrised DRAM array: valid/ready request port, pipelined reads, periodic refresh.
// Optional even-parity storage and parity_err output when DRAM_PARITY_EN is defined.
module dram_array_ctrl
  import dram_pkg::*;
#(
  parameter int DATA_W     = 72,
  parameter int DEPTH      = 4,
  parameter int RD_LAT     = 2,
  parameter int REF_PERIOD = 64,
  parameter int REF_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
`ifdef DRAM_PARITY_EN
  output logic                     parity_err,
`endif
  output logic                     refreshing
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(REF_PERIOD);
  localparam int RC_W   = $clog2(REF_CYCLES + 1);

  dram_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic              ref_pend_q, ref_pend_d;
  logic              alive_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wrap, accept, addr_ok, rd_fire, pipe_empty;
  logic [DATA_W-1:0] rd_word;

  assign wrap       = (cnt_q == CNT_W'(REF_PERIOD - 1));
  // alive_q holds req_ready low until the first edge after reset release.
  assign req_ready  = alive_q & accepts_req(state_q);
  assign accept     = req_valid & req_ready;
  assign addr_ok    = (int'(req_addr) < DEPTH);
  assign rd_fire    = accept & ~req_write;
  assign rd_word    = addr_ok ? mem_q[req_addr] : '0;
  assign refreshing = (state_q == REFRESH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rc_q       <= '0;
      ref_pend_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= wrap ? '0 : cnt_q + CNT_W'(1);
      rc_q       <= rc_d;
      ref_pend_q <= ref_pend_d;
      alive_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    ref_pend_d = ref_pend_q | wrap;
    case (state_q)
      IDLE: begin
        if (wrap || ref_pend_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = REFRESH;
          rc_d    = '0;
        end
      end
      REFRESH: begin
        if (rc_q == RC_W'(REF_CYCLES - 1)) begin
          state_d    = IDLE;
          ref_pend_d = 1'b0;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept && req_write && addr_ok) begin
      mem_q[req_addr] <= req_wdata;
    end
  end

`ifdef DRAM_PARITY_EN
  logic             par_q [DEPTH];
  logic [DEPTH-1:0] par_inv = '0;
  logic             rd_par, rsp_par;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
    end else if (accept && req_write && addr_ok) begin
      par_q[req_addr] <= ^req_wdata;
    end
  end

  // Bench hook: inverts the stored parity bit of one word as seen by reads.
  task automatic inj_parity_flip(input logic [ADDR_W-1:0] addr);
    par_inv[addr] = ~par_inv[addr];
  endtask

  assign rd_par     = addr_ok & (par_q[req_addr] ^ par_inv[req_addr]);
  assign parity_err = rsp_valid & (rsp_par ^ (^rsp_rdata));
`endif

  dram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (rd_fire),
    .data_i  (rd_word),
`ifdef DRAM_PARITY_EN
    .par_i   (rd_par),
    .par_o   (rsp_par),
`endif
    .valid_o (rsp_valid),
    .data_o  (rsp_rdata),
    .empty_o (pipe_empty)
  );

endmodule

// File: tb/tb_dram_array_ctrl.sv
// Bench for dram_array_ctrl: directed scenarios plus random traffic against a cycle-level model.
// Parity scenario is included when DRAM_PARITY_EN is defined.
module tb_dram_array_ctrl;

  localparam int DW     = 72;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;
  localparam int RD_LAT = 2;
  localparam int P      = 64;
  localparam int RC     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          refreshing;
`ifdef DRAM_PARITY_EN
  logic          parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit flip_mdl [DEPTH];

  dram_array_ctrl #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .RD_LAT     (RD_LAT),
    .REF_PERIOD (P),
    .REF_CYCLES (RC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
`ifdef DRAM_PARITY_EN
    .parity_err (parity_err),
`endif
    .refreshing (refreshing)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  // Reference model: cycle k counts edges since reset release. Responses are
  // scheduled RD_LAT cycles after acceptance; each counter wrap opens a busy
  // window that lasts until the last in-flight read has responded, followed by
  // RC refresh cycles.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
    bit            pe;
  } rsp_t;

  rsp_t          rq[$];
  logic [DW-1:0] mmem [DEPTH];

  initial begin
    int            k, last_rd, busy_lo, busy_hi, ref_lo, ref_hi, e;
    logic          exp_ready, exp_ref, exp_v;
    logic [DW-1:0] exp_d;
`ifdef DRAM_PARITY_EN
    logic          exp_pe;
`endif
    rsp_t          ent;
    k = 0; last_rd = -1000; busy_lo = -1; busy_hi = -1; ref_lo = -1; ref_hi = -1;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        chk_bit("m_rst_ready", req_ready, 1'b0);
        chk_bit("m_rst_rsp_valid", rsp_valid, 1'b0);
        chk_word("m_rst_rdata", rsp_rdata, '0);
        chk_bit("m_rst_refreshing", refreshing, 1'b0);
`ifdef DRAM_PARITY_EN
        chk_bit("m_rst_parity_err", parity_err, 1'b0);
`endif
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        rq.delete();
        k = 0; last_rd = -1000; busy_lo = -1; busy_hi = -1; ref_lo = -1; ref_hi = -1;
      end else begin
        exp_ready = (k >= 1) && !(k >= busy_lo && k <= busy_hi);
        exp_ref   = (k >= ref_lo && k <= ref_hi);
        exp_v     = 1'b0;
        exp_d     = '0;
`ifdef DRAM_PARITY_EN
        exp_pe    = 1'b0;
`endif
        if (rq.size() > 0 && rq[0].due == k) begin
          exp_v = 1'b1;
          exp_d = rq[0].d;
`ifdef DRAM_PARITY_EN
          exp_pe = rq[0].pe;
`endif
          void'(rq.pop_front());
        end
        chk_bit("m_req_ready", req_ready, exp_ready);
        chk_bit("m_refreshing", refreshing, exp_ref);
        chk_bit("m_rsp_valid", rsp_valid, exp_v);
        chk_word("m_rsp_rdata", rsp_rdata, exp_d);
`ifdef DRAM_PARITY_EN
        chk_bit("m_parity_err", parity_err, exp_pe);
`endif
        if (req_valid === 1'b1 && exp_ready) begin
          if (req_write === 1'b1) begin
            mmem[req_addr] = req_wdata;
          end else begin
            ent.due = k + RD_LAT;
            ent.d   = mmem[req_addr];
            ent.pe  = flip_mdl[req_addr];
            rq.push_back(ent);
            last_rd = k;
          end
        end
        if (k % P == P - 1) begin
          e = (k + 1 > last_rd + RD_LAT + 1) ? k + 1 : last_rd + RD_LAT + 1;
          busy_lo = k + 1;
          busy_hi = e + RC;
          ref_lo  = e + 1;
          ref_hi  = e + RC;
        end
        k++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] bv [4];
    logic [DW-1:0] newv;
    int            guard;
    bv[0] = 72'h0123456789ABCDEF01;
    bv[1] = 72'hFEDCBA9876543210FE;
    bv[2] = 72'h800000000000000001;
    bv[3] = 72'h5A5A5A5A5A5A5A5A5A;
    newv  = 72'h00000000000000CAFE;
    for (int i = 0; i < DEPTH; i++) flip_mdl[i] = 1'b0;

    // Reset release
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_ready", req_ready, 1'b0);
    chk_bit("rst_rsp_valid", rsp_valid, 1'b0);
    chk_word("rst_rdata", rsp_rdata, '0);
    chk_bit("rst_refreshing", refreshing, 1'b0);
    reset = 1'b1;
    cyc   = 0;
    #1;
    chk_bit("ready_before_edge", req_ready, 1'b0);
    tick();
    chk_bit("ready_after_edge", req_ready, 1'b1);

    // Write then read addr 2
    drive(1'b1, 1'b1, 2'd2, 72'd12);
    tick();
    drive(1'b1, 1'b0, 2'd2, '0);
    tick();
    idle();
    chk_bit("t2_no_early_rsp", rsp_valid, 1'b0);
    tick();
    chk_bit("t2_rsp_valid", rsp_valid, 1'b1);
    chk_word("t2_rdata", rsp_rdata, 72'd12);
    tick();
    chk_bit("t2_single_pulse", rsp_valid, 1'b0);

    // Burst writes then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, AW'(i), bv[i]);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        chk_bit("t3_rsp_valid", rsp_valid, 1'b1);
        chk_word("t3_rdata", rsp_rdata, bv[i-2]);
      end
      if (i < 4) drive(1'b1, 1'b0, AW'(i), '0);
      else       idle();
      tick();
    end

    // Refresh with a read in flight at the wrap cycle (cycle 63)
    while (cyc < P - 1) tick();
    drive(1'b1, 1'b0, 2'd1, '0);
    tick();
    drive(1'b1, 1'b0, 2'd2, '0);
    for (int c = 64; c <= 73; c++) begin
      if (c <= 70) chk_bit("t4_ready_low", req_ready, 1'b0);
      if (c == 71) chk_bit("t4_ready_back", req_ready, 1'b1);
      if (c == 72) idle();
      chk_bit("t4_refreshing", refreshing, (c >= 67 && c <= 70));
      chk_bit("t4_rsp_valid", rsp_valid, (c == 65 || c == 73));
      if (c == 65) chk_word("t4_inflight_rdata", rsp_rdata, bv[1]);
      if (c == 73) chk_word("t4_held_rdata", rsp_rdata, bv[2]);
      tick();
    end

    // Read then write the same address, then read again
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        chk_bit("t5_old_valid", rsp_valid, 1'b1);
        chk_word("t5_old_rdata", rsp_rdata, bv[3]);
      end
      if (i == 3) chk_bit("t5_gap", rsp_valid, 1'b0);
      if (i == 4) begin
        chk_bit("t5_new_valid", rsp_valid, 1'b1);
        chk_word("t5_new_rdata", rsp_rdata, newv);
      end
      case (i)
        0:       drive(1'b1, 1'b0, 2'd3, '0);
        1:       drive(1'b1, 1'b1, 2'd3, newv);
        2:       drive(1'b1, 1'b0, 2'd3, '0);
        default: idle();
      endcase
      tick();
    end

    // Random traffic across several refresh windows
    repeat (500) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, DEPTH - 1)), {8'($urandom), $urandom, $urandom});
      tick();
    end
    idle();

    // Reset with two reads in flight
    guard = 0;
    while (!(req_ready === 1'b1 && (cyc % P) < 50) && guard < 200) begin
      tick();
      guard++;
    end
    chk_bit("t6_ready_wait", (guard < 200), 1'b1);
    drive(1'b1, 1'b0, 2'd0, '0);
    tick();
    drive(1'b1, 1'b0, 2'd1, '0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk_bit("t6_rsp_in_reset", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 4; i++) begin
      chk_bit("t6_no_rsp_after_reset", rsp_valid, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 2'd0, '0);
    tick();
    drive(1'b1, 1'b0, 2'd1, '0);
    tick();
    idle();
    chk_bit("t6_rd0_valid", rsp_valid, 1'b1);
    chk_word("t6_rd0_cleared", rsp_rdata, '0);
    tick();
    chk_bit("t6_rd1_valid", rsp_valid, 1'b1);
    chk_word("t6_rd1_cleared", rsp_rdata, '0);
    tick();

`ifdef DRAM_PARITY_EN
    dut.inj_parity_flip(AW'(1));
    flip_mdl[1] = 1'b1;
    drive(1'b1, 1'b0, 2'd1, '0);
    tick();
    drive(1'b1, 1'b0, 2'd0, '0);
    tick();
    idle();
    chk_bit("par_rsp_valid", rsp_valid, 1'b1);
    chk_bit("par_err_flipped", parity_err, 1'b1);
    tick();
    chk_bit("par_rsp_valid_clean", rsp_valid, 1'b1);
    chk_bit("par_err_clean", parity_err, 1'b0);
    tick();
`endif

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
